// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single DRAM burst port, shared by I-cache refill and D-cache refill/write-back.
// Optional burst watchdog is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_val,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_data,
  output logic        d_val,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_val,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_grant;
  logic [1:0]        w_next_grant;
  logic              r_mem_req;
  logic              w_next_mem_req;
  logic              r_mem_we;
  logic              w_next_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       w_next_mem_addr;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BEAT_W-1:0] w_next_beat_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_next_gap_cnt;
  logic              r_last_d;
  logic              w_next_last_d;
  logic              w_pick_d;
  logic              w_end_burst;
  logic              w_beat;
  logic              w_timeout;

  // A beat only counts while a burst is in flight; strays in IDLE/GAP are dropped.
  assign w_beat = (r_state == ST_BURST) && mem_val;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  // Counts consecutive silent BURST cycles; the last allowed one fires the abort.
  assign w_timeout = (r_state == ST_BURST) && !mem_val && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_BURST) || mem_val || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    w_next_state    = r_state;
    w_next_grant    = r_grant;
    w_next_mem_req  = r_mem_req;
    w_next_mem_we   = r_mem_we;
    w_next_mem_addr = r_mem_addr;
    w_next_beat_cnt = r_beat_cnt;
    w_next_gap_cnt  = r_gap_cnt;
    w_next_last_d   = r_last_d;
    w_pick_d        = 1'b0;
    w_end_burst     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // D wins when alone, or on a tie when I owned the port last.
        w_pick_d = d_req && (!i_req || !r_last_d);
        if (i_req || d_req) begin
          w_next_state    = ST_BURST;
          w_next_mem_req  = 1'b1;
          w_next_grant    = w_pick_d ? 2'b10 : 2'b01;
          w_next_mem_addr = w_pick_d ? d_addr : i_addr;
          w_next_mem_we   = w_pick_d && d_we;
          w_next_last_d   = w_pick_d;
          w_next_beat_cnt = '0;
        end
      end

      ST_BURST: begin
        if (w_beat) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_end_burst = 1'b1;
          end else begin
            w_next_beat_cnt = r_beat_cnt + BEAT_W'(1);
          end
        end
        if (w_end_burst || w_timeout) begin
          w_next_state    = ST_GAP;
          w_next_mem_req  = 1'b0;
          w_next_mem_we   = 1'b0;
          w_next_grant    = 2'b00;
          w_next_beat_cnt = '0;
          w_next_gap_cnt  = '0;
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_next_state   = ST_IDLE;
          w_next_gap_cnt = '0;
        end else begin
          w_next_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        w_next_state    = ST_IDLE;
        w_next_mem_req  = 1'b0;
        w_next_mem_we   = 1'b0;
        w_next_grant    = 2'b00;
        w_next_beat_cnt = '0;
        w_next_gap_cnt  = '0;
      end
    endcase
  end

  // State and registered outputs; last owner resets to D so I wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
      r_last_d   <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_grant    <= w_next_grant;
      r_mem_req  <= w_next_mem_req;
      r_mem_we   <= w_next_mem_we;
      r_mem_addr <= w_next_mem_addr;
      r_beat_cnt <= w_next_beat_cnt;
      r_gap_cnt  <= w_next_gap_cnt;
      r_last_d   <= w_next_last_d;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign grant     = r_grant;
  assign busy      = (r_state != ST_IDLE);

  // Beat strobes and data steer to the owner only; data is shared, valid is not.
  assign i_val     = w_beat && r_grant[0];
  assign d_val     = w_beat && r_grant[1];
  assign i_data    = mem_rdata;
  assign d_data    = mem_rdata;
  assign mem_wdata = (r_grant[1] && r_mem_we) ? d_wdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: beat expectations are queued as DRAM strobes are driven.
// Define MEM_ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog with TIMEOUT=16.
module tb_mem_port_arbiter;
  localparam int unsigned BL  = 8;
  localparam int unsigned GAP = 2;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_val;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_data, d_data, mem_addr, mem_wdata;
  logic        i_val, d_val, mem_req, mem_we, busy, err;
  logic [1:0]  grant;

  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_beat;
  logic [33:0] obs_beat;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .BURST_LEN (BL),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .i_val    (i_val),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_data   (d_data),
    .d_val    (d_val),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_val  (mem_val),
    .grant    (grant),
    .busy     (busy),
    .err      (err)
  );

  // Advance to mid-cycle, drive the DRAM strobe for this cycle, let combinational outputs settle.
  task automatic cyc(input logic v, input logic [31:0] rd);
    @(negedge clk);
    mem_val   = v;
    mem_rdata = rd;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_val = 1'b0; mem_rdata = '0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, mem_we, grant, busy, err, i_val, d_val} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {mem_req, mem_we, grant, busy, err, i_val, d_val});
    end
    checks++;
    if (mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 00000000", mem_addr);
    end
    reset = 1'b0;
    cyc(1'b0, '0);
  endtask

  task automatic test_i_refill();
    i_req = 1'b1; i_addr = 32'h0000_0100;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL i_refill_req_early: got %b expected 0", mem_req);
    end
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, mem_we, grant, busy, mem_addr} !== {1'b1, 1'b0, 2'b01, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL i_refill_grant: got %h expected %h", {mem_req, mem_we, grant, busy, mem_addr},
               {1'b1, 1'b0, 2'b01, 1'b1, 32'h100});
    end
    for (int k = 0; k < int'(BL); k++) begin
      exp_q.push_back({2'b01, 32'hA0 + 32'(k)});
      cyc(1'b1, 32'hA0 + 32'(k));
      obs_beat = {d_val, i_val, i_val ? i_data : d_data};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL i_refill_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, grant, busy, err} !== {1'b0, 2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL i_refill_end: got %b expected 00010", {mem_req, grant, busy, err});
    end
    i_req = 1'b0;
    cyc(1'b0, '0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL i_refill_gap2: busy got %b expected 1", busy);
    end
    cyc(1'b0, '0);
    checks++;
    if ({busy, mem_req, grant} !== 4'b0000) begin
      errors++;
      $display("FAIL i_refill_idle: got %b expected 0000", {busy, mem_req, grant});
    end
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    cyc(1'b0, '0);
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int g = 0; g < 3; g++) begin
      logic [1:0]  exp_grant;
      logic [31:0] exp_addr;
      exp_grant = (g == 1) ? 2'b10 : 2'b01;
      exp_addr  = (g == 1) ? 32'h200 : 32'h300;
      cyc(1'b0, '0);
      checks++;
      if ({grant, mem_addr} !== {exp_grant, exp_addr}) begin
        errors++;
        $display("FAIL simul_grant%0d: got %h expected %h", g, {grant, mem_addr}, {exp_grant, exp_addr});
      end
      for (int k = 0; k < int'(BL); k++) begin
        exp_q.push_back({exp_grant[1], exp_grant[0], 32'hB0 + 32'(16 * g + k)});
        cyc(1'b1, 32'hB0 + 32'(16 * g + k));
        obs_beat = {d_val, i_val, i_val ? i_data : d_data};
        exp_beat = exp_q.pop_front();
        checks++;
        if (obs_beat !== exp_beat) begin
          errors++;
          $display("FAIL simul_beat%0d_%0d: got %h expected %h", g, k, obs_beat, exp_beat);
        end
      end
      cyc(1'b0, '0);
      if (g == 2) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      cyc(1'b0, '0);
      cyc(1'b0, '0);
      checks++;
      if ({busy, grant} !== 3'b000) begin
        errors++;
        $display("FAIL simul_idle%0d: got %b expected 000", g, {busy, grant});
      end
    end
  endtask

  task automatic test_d_writeback();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h10;
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, mem_we, grant, mem_addr} !== {1'b1, 1'b1, 2'b10, 32'h40}) begin
      errors++;
      $display("FAIL wb_grant: got %h expected %h", {mem_req, mem_we, grant, mem_addr}, {1'b1, 1'b1, 2'b10, 32'h40});
    end
    for (int k = 0; k < int'(BL); k++) begin
      cyc(1'b0, '0);
      d_wdata = 32'h10 + 32'(k);
      #1;
      checks++;
      if ({d_val, mem_wdata} !== {1'b0, 32'h10 + 32'(k)}) begin
        errors++;
        $display("FAIL wb_wait%0d: got %h expected %h", k, {d_val, mem_wdata}, {1'b0, 32'h10 + 32'(k)});
      end
      exp_q.push_back({2'b10, 32'h10 + 32'(k)});
      cyc(1'b1, 32'hDEAD_0000);
      obs_beat = {d_val, i_val, mem_wdata};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL wb_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, grant, mem_wdata} !== {1'b0, 2'b00, 32'd0}) begin
      errors++;
      $display("FAIL wb_end: got %h expected 0", {mem_req, grant, mem_wdata});
    end
    d_req = 1'b0; d_we = 1'b0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
  endtask

  task automatic test_stray();
    cyc(1'b1, 32'hEE);
    checks++;
    if ({d_val, i_val, busy} !== 3'b000) begin
      errors++;
      $display("FAIL stray_idle: got %b expected 000", {d_val, i_val, busy});
    end
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    #1;
    checks++;
    if ({d_val, i_val} !== 2'b00) begin
      errors++;
      $display("FAIL stray_idle_req: got %b expected 00", {d_val, i_val});
    end
    for (int k = 0; k < int'(BL); k++) begin
      exp_q.push_back({2'b01, 32'hE0 + 32'(k)});
      cyc(1'b1, 32'hE0 + 32'(k));
      obs_beat = {d_val, i_val, i_val ? i_data : d_data};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL stray_i_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    cyc(1'b1, 32'h55);
    checks++;
    if ({d_val, i_val, mem_req, grant} !== 5'b00000) begin
      errors++;
      $display("FAIL stray_gap1: got %b expected 00000", {d_val, i_val, mem_req, grant});
    end
    i_req = 1'b0;
    cyc(1'b1, 32'h56);
    checks++;
    if ({d_val, i_val} !== 2'b00) begin
      errors++;
      $display("FAIL stray_gap2: got %b expected 00", {d_val, i_val});
    end
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    checks++;
    if ({grant, mem_addr} !== {2'b10, 32'h600}) begin
      errors++;
      $display("FAIL stray_d_grant: got %h expected %h", {grant, mem_addr}, {2'b10, 32'h600});
    end
    for (int k = 0; k < int'(BL); k++) begin
      exp_q.push_back({2'b10, 32'h60 + 32'(k)});
      cyc(1'b1, 32'h60 + 32'(k));
      obs_beat = {d_val, i_val, i_val ? i_data : d_data};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL stray_d_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, grant} !== 3'b000) begin
      errors++;
      $display("FAIL stray_d_end: got %b expected 000", {mem_req, grant});
    end
    d_req = 1'b0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
  endtask

  task automatic test_reset_mid_burst();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    cyc(1'b0, '0);
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_grant: got %b expected 10", grant);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({2'b10, 32'hF0 + 32'(k)});
      cyc(1'b1, 32'hF0 + 32'(k));
      obs_beat = {d_val, i_val, i_val ? i_data : d_data};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL rst_mid_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    reset = 1'b1;
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, mem_we, grant, busy, err, mem_addr} !== 38'd0) begin
      errors++;
      $display("FAIL rst_mid_clear: got %h expected 0", {mem_req, mem_we, grant, busy, err, mem_addr});
    end
    reset = 1'b0;
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h800;
    cyc(1'b0, '0);
    checks++;
    if ({grant, mem_addr} !== {2'b01, 32'h800}) begin
      errors++;
      $display("FAIL rst_mid_regrant: got %h expected %h", {grant, mem_addr}, {2'b01, 32'h800});
    end
    for (int k = 0; k < int'(BL); k++) begin
      exp_q.push_back({2'b01, 32'h80 + 32'(k)});
      cyc(1'b1, 32'h80 + 32'(k));
      obs_beat = {d_val, i_val, i_val ? i_data : d_data};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL rst_mid_i_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    cyc(1'b0, '0);
    checks++;
    if ({mem_req, grant} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_i_end: got %b expected 000", {mem_req, grant});
    end
    i_req = 1'b0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    i_req = 1'b1; i_addr = 32'h900;
    cyc(1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({2'b01, 32'h90 + 32'(k)});
      cyc(1'b1, 32'h90 + 32'(k));
      obs_beat = {d_val, i_val, i_val ? i_data : d_data};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL tmo_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    // 16 silent cycles follow beat 2; err is seen in the cycle after them.
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      cyc(1'b0, '0);
      n++;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles expected 17", n);
    end
    checks++;
    if ({mem_req, grant, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL tmo_abort: got %b expected 0001", {mem_req, grant, busy});
    end
    cyc(1'b0, '0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: err got %b expected 0", err);
    end
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    checks++;
    if ({grant, mem_addr} !== {2'b01, 32'h900}) begin
      errors++;
      $display("FAIL tmo_regrant: got %h expected %h", {grant, mem_addr}, {2'b01, 32'h900});
    end
    for (int k = 0; k < int'(BL); k++) begin
      exp_q.push_back({2'b01, 32'h90 + 32'(k)});
      cyc(1'b1, 32'h90 + 32'(k));
      obs_beat = {d_val, i_val, i_val ? i_data : d_data};
      exp_beat = exp_q.pop_front();
      checks++;
      if (obs_beat !== exp_beat) begin
        errors++;
        $display("FAIL tmo_retry_beat%0d: got %h expected %h", k, obs_beat, exp_beat);
      end
    end
    cyc(1'b0, '0);
    i_req = 1'b0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_i_refill();
    test_simultaneous();
    test_d_writeback();
    test_stray();
    test_reset_mid_burst();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single DRAM burst port between the instruction-cache refill path and the data-cache refill/write-back path. It grants one requester at a time using round-robin, then sequences a fixed-length burst of BURST_LEN words. Read data and per-beat valids go only to the granted side. It sits between the two cache controllers and the DRAM model/controller.

Parameters:
BURST_LEN, 8, words per burst (must be ≥1; beat counter width is clog2(BURST_LEN)+1)
GAP_CYCLES, 2, idle cycles after last beat before re-arbitration, so requesters can drop their level req
TIMEOUT, 255, cycles without mem_val before a burst is aborted (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  I-side read-burst request, level, held until burst completes
i_addr  in  32  I-side burst word address, block-aligned
i_data  out  32  read data to I-side (copy of mem_rdata)
i_val  out  1  read-beat valid to I-side
d_req  in  1  D-side burst request, level
d_we  in  1  D-side burst direction: 1 = write-back, 0 = refill
d_addr  in  32  D-side burst word address
d_wdata  in  32  current write word from D-side; advanced by D-side on each d_val
d_data  out  32  read data to D-side
d_val  out  1  beat valid to D-side (read data valid, or write word accepted)
mem_req  out  1  burst request to DRAM, registered
mem_we  out  1  burst direction to DRAM, registered
mem_addr  out  32  latched burst address, registered
mem_wdata  out  32  write word to DRAM (pass-through of d_wdata while D is granted with we=1, else 0)
mem_rdata  in  32  read word from DRAM
mem_val  in  1  DRAM beat strobe: read word valid or write word accepted
grant  out  2  one-hot owner: [0] = I, [1] = D; 00 when idle
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle timeout pulse (0 when feature is compiled out)

Behaviour:
- States: IDLE, BURST, GAP.
- Reset: state IDLE; mem_req, mem_we, grant, busy, err = 0; mem_addr = 0; beat count = 0; last_owner = D, so I wins the first tie.
- IDLE transitions:
  - exactly one req high → grant that side.
  - both high → grant the side other than last_owner.
  - none → stay in IDLE.
- On grant (IDLE→BURST edge):
  - latch addr into mem_addr; mem_we = d_we for D, 0 for I.
  - mem_req = 1; grant updates the same edge; last_owner updated.
  - mem_req is visible 1 cycle after the req is sampled.
- BURST:
  - each mem_val increments the beat count and produces a same-cycle combinational x_val to the owner only.
  - x_data = mem_rdata for both sides, always; the non-owner's val is forced to 0.
  - mem_val arriving in IDLE or GAP is ignored: no val to either side, no count change.
- Last beat (count reaches BURST_LEN on that mem_val):
  - at the next edge mem_req = 0, grant = 00, state = GAP, beat count cleared.
- GAP: lasts exactly GAP_CYCLES cycles, then IDLE; requests are not sampled during GAP.
- Requester dropping req mid-burst is a protocol violation; the arbiter ignores it and completes the burst.
- busy = (state != IDLE).
- Reset asserted mid-burst: everything returns to reset values next edge; any partial burst is discarded.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - a cycle counter runs in BURST, cleared on each mem_val.
  - reaching TIMEOUT → mem_req dropped, grant cleared, state GAP, err pulses high for one cycle.
  - the requester's req is still high, so it re-arbitrates after GAP.
- Undefined: no counter is synthesized, err is tied 0, and BURST waits indefinitely.

Test Plan:
- Single I refill:
  - stimulus: i_req=1, i_addr=0x0000_0100; DRAM returns 8 beats 0xA0..0xA7 one per cycle.
  - response: mem_req rises 1 cycle after i_req; mem_addr=0x100, mem_we=0; i_val pulses 8 times with data 0xA0..0xA7; d_val stays 0; mem_req falls the edge after beat 8; 2 GAP cycles, then IDLE.
- Simultaneous requests after reset:
  - stimulus: i_req and d_req rise in the same cycle.
  - response: grant=01 (I) first; after I's burst plus GAP, grant=10 (D); with both still requesting, next grant returns to I (alternation).
- D write-back:
  - stimulus: d_req=1, d_we=1, d_addr=0x40; D-side advances d_wdata 0x10..0x17 on d_val; mem_val every other cycle.
  - response: mem_we=1; mem_wdata matches d_wdata each beat; 8 d_val pulses; burst ends after the 8th accepted word.
- Stray and non-owner strobes:
  - stimulus: mem_val pulses while IDLE and during GAP; during an I burst, d_req is high.
  - response: no x_val to either side and count unchanged in IDLE/GAP; d_val stays 0 throughout the I burst.
- Reset mid-burst:
  - stimulus: reset asserted after 3 beats of a D refill.
  - response: next edge mem_req=0, grant=00, busy=0; a new i_req then completes a full 8-beat burst.
- Timeout (with MEM_ARB_TIMEOUT_EN, TIMEOUT=16):
  - stimulus: I burst gets 2 beats, then no mem_val.
  - response: 16 cycles after beat 2, err pulses one cycle and mem_req=0; after GAP, I is re-granted with mem_addr unchanged.
